// File: rtl/nx_stat_counter_pkg.sv
`timescale 1ns/1ps
// Operation codes shared by the stat counter controller and its front-end arbiter.
package nx_stat_counter_pkg;
    typedef enum logic [1:0] {
        OP_COUNT      = 2'd0,
        OP_READ       = 2'd1,
        OP_READ_CLEAR = 2'd2,
        OP_WRITE      = 2'd3
    } counter_op_e;
endpackage

// File: rtl/nx_stat_counter_arb.sv
`timescale 1ns/1ps
// Shares the counter controller's request port between N_CLIENTS counting clients and
// one software port, and steers the controller's software responses back to software.
module nx_stat_counter_arb
    import nx_stat_counter_pkg::*;
#(
    parameter int N_CLIENTS   = 4,
    parameter int N_ENTRIES   = 1024,
    parameter int TOTAL_WIDTH = 70,
    parameter int ID_WIDTH    = $clog2(N_CLIENTS + 1),
    localparam int AW         = $clog2(N_ENTRIES)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_CLIENTS-1:0]                  cnt_valid,
    output logic [N_CLIENTS-1:0]                  cnt_ready,
    input  logic [N_CLIENTS-1:0][AW-1:0]          cnt_addr,
    input  logic [N_CLIENTS-1:0][TOTAL_WIDTH-1:0] cnt_data,
    input  logic                                  sw_valid,
    output logic                                  sw_ready,
    input  logic [AW-1:0]                         sw_addr,
    input  counter_op_e                           sw_op,
    input  logic [TOTAL_WIDTH-1:0]                sw_data,
    output logic                                  sw_rsp_valid,
    input  logic                                  sw_rsp_ready,
    output logic [TOTAL_WIDTH-1:0]                sw_rsp_data,
    output logic                                  req_valid,
    input  logic                                  req_ready,
    output logic [AW-1:0]                         req_addr,
    output logic [TOTAL_WIDTH-1:0]                req_data,
    output logic [ID_WIDTH-1:0]                   req_id,
    output counter_op_e                           req_op,
    input  logic                                  rsp_valid,
    output logic                                  rsp_ready,
    input  logic [TOTAL_WIDTH-1:0]                rsp_data,
    input  logic [ID_WIDTH-1:0]                   rsp_id
);
    localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [ID_WIDTH-1:0] SW_ID = ID_WIDTH'(N_CLIENTS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CLIENTS - 1);

    logic             out_v;
    logic             sw_pending;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cli_idx;
    logic [PTR_W-1:0] cand;
    logic             cli_hit;
    logic             grant_en;
    logic             sw_grant;
    logic             cli_grant;
    logic             sw_hs;
    logic             sw_rsp_take;

    // Grants only happen when the output register can take a new request this cycle.
    assign grant_en    = !rst && (!out_v || req_ready);
    assign sw_grant    = grant_en && sw_valid && !sw_pending;
    assign cli_grant   = grant_en && !sw_grant && cli_hit;
    assign sw_ready    = sw_grant;
    assign sw_hs       = sw_rsp_valid && sw_rsp_ready;
    assign sw_rsp_take = rsp_valid && (rsp_id == SW_ID) && sw_pending && !sw_rsp_valid;
    assign rsp_ready   = 1'b1;
    assign req_valid   = out_v;

    always_comb begin
        cli_hit = 1'b0;
        cli_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % N_CLIENTS);
            if (!cli_hit && cnt_valid[cand]) begin
                cli_hit = 1'b1;
                cli_idx = cand;
            end
        end
    end

    always_comb begin
        cnt_ready = '0;
        if (cli_grant) cnt_ready[cli_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v        <= 1'b0;
            rr_ptr       <= '0;
            sw_pending   <= 1'b0;
            sw_rsp_valid <= 1'b0;
        end else begin
            if (grant_en) out_v <= sw_grant || cli_grant;
            if (cli_grant) rr_ptr <= (cli_idx == LAST_IDX) ? '0 : cli_idx + 1'b1;
            if (sw_grant) sw_pending <= 1'b1;
            else if (sw_hs) sw_pending <= 1'b0;
            if (sw_rsp_take) sw_rsp_valid <= 1'b1;
            else if (sw_hs) sw_rsp_valid <= 1'b0;
        end
    end

    // Payload is left unreset; it only matters while out_v / sw_rsp_valid say so.
    always_ff @(posedge clk) begin
        if (sw_grant) begin
            req_op   <= sw_op;
            req_id   <= SW_ID;
            req_addr <= sw_addr;
            req_data <= sw_data;
        end else if (cli_grant) begin
            req_op   <= OP_COUNT;
            req_id   <= ID_WIDTH'(cli_idx);
            req_addr <= cnt_addr[cli_idx];
            req_data <= cnt_data[cli_idx];
        end
        if (sw_rsp_take) sw_rsp_data <= rsp_data;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && rsp_valid) assert (rsp_id <= SW_ID);
    end
`endif

endmodule

// File: tb/tb_nx_stat_counter_arb.sv
`timescale 1ns/1ps
// Self-checking bench for nx_stat_counter_arb: vector table, directed corner sequences
// and randomized traffic, all compared against a behavioural model of the arbiter.
module tb_nx_stat_counter_arb;
    import nx_stat_counter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int TW = 70;

    logic                      clk;
    logic                      rst;
    logic [N-1:0]              cnt_valid;
    logic [N-1:0]              cnt_ready;
    logic [N-1:0][AW-1:0]      cnt_addr;
    logic [N-1:0][TW-1:0]      cnt_data;
    logic                      sw_valid;
    logic                      sw_ready;
    logic [AW-1:0]             sw_addr;
    counter_op_e               sw_op;
    logic [TW-1:0]             sw_data;
    logic                      sw_rsp_valid;
    logic                      sw_rsp_ready;
    logic [TW-1:0]             sw_rsp_data;
    logic                      req_valid;
    logic                      req_ready;
    logic [AW-1:0]             req_addr;
    logic [TW-1:0]             req_data;
    logic [2:0]                req_id;
    counter_op_e               req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [TW-1:0]             rsp_data;
    logic [2:0]                rsp_id;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the output register and software path should hold.
    bit          m_out_v;
    logic [2:0]  m_id;
    counter_op_e m_op;
    logic [AW-1:0] m_addr;
    logic [TW-1:0] m_data;
    int          m_rr;
    bit          m_pend;
    bit          m_rspv;
    logic [TW-1:0] m_rspd;

    typedef struct {
        logic [3:0] cnt_valid;
        logic       sw_valid;
        logic       req_ready;
        logic [3:0] exp_cnt_ready;
        logic       exp_sw_ready;
        logic       exp_req_valid;
        logic [2:0] exp_req_id;
    } vec_t;

    vec_t vecs [12];

    nx_stat_counter_arb #(
        .N_CLIENTS(N), .N_ENTRIES(1024), .TOTAL_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_addr(cnt_addr), .cnt_data(cnt_data),
        .sw_valid(sw_valid), .sw_ready(sw_ready), .sw_addr(sw_addr), .sw_op(sw_op), .sw_data(sw_data),
        .sw_rsp_valid(sw_rsp_valid), .sw_rsp_ready(sw_rsp_ready), .sw_rsp_data(sw_rsp_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
        .req_id(req_id), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected done", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Software wins if nothing is outstanding, else first requesting client from rr.
    function automatic void model_grant(output bit sw_g, output bit cli_g, output int k);
        sw_g  = 1'b0;
        cli_g = 1'b0;
        k     = 0;
        if (rst || !(!m_out_v || req_ready)) return;
        if (sw_valid && !m_pend) begin
            sw_g = 1'b1;
            return;
        end
        for (int i = 0; i < N; i++) begin
            k = (m_rr + i) % N;
            if (cnt_valid[k]) begin
                cli_g = 1'b1;
                return;
            end
        end
        k = 0;
    endfunction

    // Settle current inputs, check combinational outputs, then advance the model.
    task automatic applyStimulus();
        bit sw_g, cli_g, hs, take;
        int k;
        logic [3:0] exp_ready;
        #1;
        model_grant(sw_g, cli_g, k);
        exp_ready = cli_g ? 4'(1 << k) : 4'h0;
        checkOutput("cnt_ready", 128'(cnt_ready), 128'(exp_ready));
        checkOutput("sw_ready", 128'(sw_ready), 128'(sw_g));
        checkOutput("rsp_ready", 128'(rsp_ready), 128'(1'b1));
        if (rst) begin
            m_out_v = 1'b0;
            m_rr    = 0;
            m_pend  = 1'b0;
            m_rspv  = 1'b0;
        end else begin
            hs   = m_rspv && sw_rsp_ready;
            take = rsp_valid && (rsp_id == 3'(N)) && m_pend && !m_rspv;
            if (!m_out_v || req_ready) m_out_v = sw_g || cli_g;
            if (sw_g) begin
                m_id = 3'(N); m_op = sw_op; m_addr = sw_addr; m_data = sw_data; m_pend = 1'b1;
            end else if (cli_g) begin
                m_id = 3'(k); m_op = OP_COUNT; m_addr = cnt_addr[k]; m_data = cnt_data[k];
                m_rr = (k + 1) % N;
            end
            if (hs) begin
                m_pend = 1'b0;
                m_rspv = 1'b0;
            end
            if (take) begin
                m_rspv = 1'b1;
                m_rspd = rsp_data;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("req_valid", 128'(req_valid), 128'(m_out_v));
        if (m_out_v) begin
            checkOutput("req_id", 128'(req_id), 128'(m_id));
            checkOutput("req_op", 128'(req_op), 128'(m_op));
            checkOutput("req_addr", 128'(req_addr), 128'(m_addr));
            checkOutput("req_data", 128'(req_data), 128'(m_data));
        end
        checkOutput("sw_rsp_valid", 128'(sw_rsp_valid), 128'(m_rspv));
        if (m_rspv) checkOutput("sw_rsp_data", 128'(sw_rsp_data), 128'(m_rspd));
    endtask

    task automatic cycle();
        applyStimulus();
        tick();
    endtask

    initial begin
        rst = 1'b1; cnt_valid = '0; sw_valid = 1'b0; sw_op = OP_READ_CLEAR; sw_addr = 10'h155;
        sw_data = 70'h12_3456_789a_bcde_f012; sw_rsp_ready = 1'b1; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_id = '0; rsp_data = '0;
        for (int k = 0; k < N; k++) begin
            cnt_addr[k] = AW'(256 + k);
            cnt_data[k] = TW'(k + 1);
        end
        m_out_v = 1'b0; m_rr = 0; m_pend = 1'b0; m_rspv = 1'b0;

        vecs[0]  = '{4'hf, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{4'hf, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 3'd1};
        vecs[2]  = '{4'hf, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 3'd4};
        vecs[3]  = '{4'hf, 1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 3'd2};
        vecs[4]  = '{4'hf, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 3'd3};
        vecs[5]  = '{4'hf, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 3'd0};
        vecs[6]  = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0};
        vecs[7]  = '{4'h5, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 3'd2};
        vecs[8]  = '{4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd2};
        vecs[9]  = '{4'h5, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 3'd0};
        vecs[10] = '{4'h8, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 3'd3};
        vecs[11] = '{4'h1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 3'd0};

        cycle();
        cycle();
        checkOutput("reset_req_valid", 128'(req_valid), 128'(1'b0));
        checkOutput("reset_sw_rsp_valid", 128'(sw_rsp_valid), 128'(1'b0));
        rst = 1'b0;

        // Round-robin, software priority, idle, backpressure and wrap from the table.
        foreach (vecs[i]) begin
            cnt_valid = vecs[i].cnt_valid;
            sw_valid  = vecs[i].sw_valid;
            req_ready = vecs[i].req_ready;
            applyStimulus();
            checkOutput("tbl_cnt_ready", 128'(cnt_ready), 128'(vecs[i].exp_cnt_ready));
            checkOutput("tbl_sw_ready", 128'(sw_ready), 128'(vecs[i].exp_sw_ready));
            tick();
            checkOutput("tbl_req_valid", 128'(req_valid), 128'(vecs[i].exp_req_valid));
            if (vecs[i].exp_req_valid) begin
                checkOutput("tbl_req_id", 128'(req_id), 128'(vecs[i].exp_req_id));
                if (vecs[i].exp_req_id == 3'd4) begin
                    checkOutput("tbl_req_op", 128'(req_op), 128'(OP_READ_CLEAR));
                    checkOutput("tbl_req_addr", 128'(req_addr), 128'(10'h155));
                end else begin
                    checkOutput("tbl_req_op", 128'(req_op), 128'(OP_COUNT));
                    checkOutput("tbl_req_addr", 128'(req_addr), 128'(AW'(256 + int'(vecs[i].exp_req_id))));
                end
            end
        end

        // Reset while a software op is pending, then a late software-id response.
        rst = 1'b1; cnt_valid = 4'hf; sw_valid = 1'b1; req_ready = 1'b1;
        applyStimulus();
        checkOutput("rstmid_cnt_ready", 128'(cnt_ready), 128'(4'h0));
        checkOutput("rstmid_sw_ready", 128'(sw_ready), 128'(1'b0));
        tick();
        checkOutput("rstmid_req_valid", 128'(req_valid), 128'(1'b0));
        rst = 1'b0; cnt_valid = '0; sw_valid = 1'b0;
        rsp_valid = 1'b1; rsp_id = 3'd4; rsp_data = 70'h0dead;
        cycle();
        checkOutput("late_rsp_dropped", 128'(sw_rsp_valid), 128'(1'b0));
        rsp_valid = 1'b0; sw_valid = 1'b1; sw_op = OP_READ; sw_addr = 10'h02a;
        applyStimulus();
        checkOutput("post_rst_sw_ready", 128'(sw_ready), 128'(1'b1));
        tick();

        // Second software request waits for the first one's response handshake.
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                rsp_valid = 1'b1; rsp_id = 3'd4; rsp_data = 70'h3_0000_0005;
            end
            applyStimulus();
            checkOutput("sw_ready_blocked", 128'(sw_ready), 128'(1'b0));
            tick();
        end
        rsp_valid = 1'b0;
        checkOutput("sw_rsp_valid_set", 128'(sw_rsp_valid), 128'(1'b1));
        checkOutput("sw_rsp_data_val", 128'(sw_rsp_data), 128'(70'h3_0000_0005));
        applyStimulus();
        checkOutput("sw_ready_in_hs", 128'(sw_ready), 128'(1'b0));
        tick();
        applyStimulus();
        checkOutput("sw_ready_after_hs", 128'(sw_ready), 128'(1'b1));
        tick();

        // Retire that op, then only responses that must be dropped.
        sw_valid = 1'b0; rsp_valid = 1'b1; rsp_id = 3'd4; rsp_data = 70'h77;
        cycle();
        rsp_valid = 1'b0;
        cycle();
        for (int id = 0; id <= N; id++) begin
            rsp_valid = 1'b1; rsp_id = 3'(id); rsp_data = TW'(id + 100);
            applyStimulus();
            checkOutput("filter_rsp_ready", 128'(rsp_ready), 128'(1'b1));
            tick();
            checkOutput("filter_sw_rsp_valid", 128'(sw_rsp_valid), 128'(1'b0));
        end
        rsp_valid = 1'b0;

        // Backpressure with a full output slot.
        cnt_valid = 4'hf; req_ready = 1'b1;
        cycle();
        req_ready = 1'b0; sw_valid = 1'b1; sw_op = OP_WRITE; sw_addr = 10'h3ff;
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            checkOutput("bp_cnt_ready", 128'(cnt_ready), 128'(4'h0));
            checkOutput("bp_sw_ready", 128'(sw_ready), 128'(1'b0));
            tick();
        end
        req_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_release_sw_ready", 128'(sw_ready), 128'(1'b1));
        tick();
        sw_valid = 1'b0;
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            cnt_valid    = N'($urandom);
            sw_valid     = 1'($urandom);
            sw_op        = counter_op_e'($urandom_range(0, 3));
            sw_addr      = AW'($urandom);
            sw_data      = TW'({$urandom, $urandom, $urandom});
            for (int k = 0; k < N; k++) begin
                cnt_addr[k] = AW'($urandom);
                cnt_data[k] = TW'({$urandom, $urandom, $urandom});
            end
            req_ready    = ($urandom_range(0, 3) != 0);
            sw_rsp_ready = 1'($urandom);
            rsp_valid    = ($urandom_range(0, 2) == 0);
            rsp_id       = 3'($urandom_range(0, N));
            rsp_data     = TW'({$urandom, $urandom, $urandom});
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
